// File: rtl/pkt_ts_capture.sv
// Packet timestamp capture: forwards NetFPGA words through a FIFO, classifies IPv4
// packets by protocol/destination IP and records start-of-packet timestamps into a slot ring.
module pkt_ts_capture #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned CTRL_WIDTH      = 8,
  parameter int unsigned NUM_SLOTS       = 8,
  parameter int unsigned TS_WIDTH        = 32,
  parameter int unsigned FIFO_DEPTH_BITS = 5,
  parameter int unsigned CNT_WIDTH       = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic [CTRL_WIDTH-1:0]         in_ctrl,
  input  logic                          in_wr,
  output logic                          in_rdy,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [CTRL_WIDTH-1:0]         out_ctrl,
  output logic                          out_wr,
  input  logic                          out_rdy,
  input  logic                          cfg_enable,
  input  logic                          cfg_wrap,
  input  logic                          cfg_proto_en,
  input  logic [7:0]                    cfg_proto,
  input  logic                          cfg_dip_en,
  input  logic [31:0]                   cfg_dip,
  input  logic                          cfg_clear,
  output logic [NUM_SLOTS*TS_WIDTH-1:0] ts_slots,
  output logic [NUM_SLOTS-1:0]          slot_valid,
  output logic [$clog2(NUM_SLOTS)-1:0]  wr_ptr,
  output logic                          full,
  output logic [CNT_WIDTH-1:0]          match_count,
  output logic [CNT_WIDTH-1:0]          pkt_count
);

  localparam int unsigned PW = $clog2(NUM_SLOTS);
  localparam int unsigned FD = 1 << FIFO_DEPTH_BITS;
  localparam int unsigned CW = FIFO_DEPTH_BITS + 1;
  localparam int unsigned WW = DATA_WIDTH + CTRL_WIDTH;
  localparam logic [CW-1:0] FIFO_FULL = CW'(FD);
  localparam logic [CW-1:0] FIFO_NF   = CW'(FD - 2);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PARSE, S_EVAL, S_WAIT} state_t;

  // ---------------- forwarding FIFO ----------------
  logic [WW-1:0]              r_mem [FD];
  logic [FIFO_DEPTH_BITS-1:0] r_fifo_rd;
  logic [FIFO_DEPTH_BITS-1:0] r_fifo_wr;
  logic [CW-1:0]              r_fifo_cnt;
  logic                       w_empty;
  logic                       w_push;
  logic                       w_pop;
  logic [WW-1:0]              w_head;

  assign w_empty  = (r_fifo_cnt == '0);
  assign w_push   = in_wr && (r_fifo_cnt != FIFO_FULL) && !reset;
  assign w_pop    = !w_empty && out_rdy && !reset;
  assign w_head   = r_mem[r_fifo_rd];
  assign in_rdy   = (r_fifo_cnt < FIFO_NF) && out_rdy;
  assign out_wr   = w_pop;
  // Head is masked while nothing valid is held so stale words never appear on the bus
  assign out_ctrl = (w_empty || reset) ? '0 : w_head[WW-1 -: CTRL_WIDTH];
  assign out_data = (w_empty || reset) ? '0 : w_head[DATA_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_fifo_wr] <= {in_ctrl, in_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fifo_rd  <= '0;
      r_fifo_wr  <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) r_fifo_wr <= r_fifo_wr + 1'b1;
      if (w_pop)  r_fifo_rd <= r_fifo_rd + 1'b1;
      if (w_push && !w_pop)      r_fifo_cnt <= r_fifo_cnt + 1'b1;
      else if (!w_push && w_pop) r_fifo_cnt <= r_fifo_cnt - 1'b1;
    end
  end

  // ---------------- free-running timestamp ----------------
  logic [TS_WIDTH-1:0] r_ts;

  always_ff @(posedge clk) begin
    if (reset) r_ts <= '0;
    else       r_ts <= r_ts + 1'b1;
  end

  // ---------------- parser FSM ----------------
  state_t              r_state;
  logic [2:0]          r_w;
  logic [TS_WIDTH-1:0] r_sop_ts;
  logic [15:0]         r_ethertype;
  logic [7:0]          r_proto;
  logic [15:0]         r_dip_hi;
  logic [15:0]         r_dip_lo;
  logic                r_match;
  logic                w_eop;
  logic [15:0]         w_dip_lo;
  logic                w_is_ip;
  logic                w_match;
  logic                w_eval;
  logic                w_capture;

  assign w_eop    = (out_ctrl != '0);
  // The final DIP half can arrive together with EOP, so it is taken straight off the bus in PARSE
  assign w_dip_lo = (r_state == S_PARSE) ? out_data[63:48] : r_dip_lo;
  assign w_is_ip  = (r_ethertype == 16'h0800);
  assign w_match  = w_is_ip && (!cfg_proto_en || (r_proto == cfg_proto))
                    && (!cfg_dip_en || ({r_dip_hi, w_dip_lo} == cfg_dip));
  assign w_eval   = (r_state == S_EVAL) ||
                    ((r_state == S_PARSE) && (r_w == 3'd4) && w_pop && w_eop);
  assign full     = (&slot_valid) && !cfg_wrap;
  assign w_capture = w_pop && w_eop && cfg_enable && !full &&
                     (((r_state == S_WAIT) && r_match) || (w_eval && w_match));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_w         <= '0;
      r_sop_ts    <= '0;
      r_ethertype <= '0;
      r_proto     <= '0;
      r_dip_hi    <= '0;
      r_dip_lo    <= '0;
      r_match     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_pop && w_eop) r_state <= S_HDR;
        S_HDR: begin
          if (w_pop && !w_eop) begin
            r_sop_ts <= r_ts;
            r_w      <= 3'd1;
            r_state  <= S_PARSE;
          end
        end
        S_PARSE: begin
          if (w_pop) begin
            r_w <= r_w + 3'd1;
            if (w_eop) r_state <= S_IDLE;
            else begin
              unique case (r_w)
                3'd1: r_ethertype <= out_data[31:16];
                3'd2: r_proto     <= out_data[7:0];
                3'd3: r_dip_hi    <= out_data[15:0];
                3'd4: begin
                  r_dip_lo <= out_data[63:48];
                  r_state  <= S_EVAL;
                end
                default: ;
              endcase
            end
          end
        end
        S_EVAL: begin
          r_match <= w_match;
          r_state <= (w_pop && w_eop) ? S_IDLE : S_WAIT;
        end
        S_WAIT: if (w_pop && w_eop) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- capture slots and counters ----------------
  logic [TS_WIDTH-1:0] r_slots [NUM_SLOTS];

  always_ff @(posedge clk) begin
    if (reset || cfg_clear) begin
      r_slots     <= '{default: '0};
      slot_valid  <= '0;
      wr_ptr      <= '0;
      match_count <= '0;
      pkt_count   <= '0;
    end else begin
      if (w_eval && w_is_ip && (pkt_count != '1)) pkt_count <= pkt_count + 1'b1;
      if (w_capture) begin
        r_slots[wr_ptr]    <= r_sop_ts;
        slot_valid[wr_ptr] <= 1'b1;
        wr_ptr             <= PW'(wr_ptr + 1'b1);
        if (match_count != '1) match_count <= match_count + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_flat
    assign ts_slots[k*TS_WIDTH +: TS_WIDTH] = r_slots[k];
  end

endmodule

// File: tb/tb_pkt_ts_capture.sv
// Directed bench for pkt_ts_capture: forwarding integrity, filtering, ring modes and clear.
module tb_pkt_ts_capture;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  in_data;
  logic [7:0]   in_ctrl;
  logic         in_wr;
  logic         in_rdy;
  logic [63:0]  out_data;
  logic [7:0]   out_ctrl;
  logic         out_wr;
  logic         out_rdy = 1'b1;
  logic         cfg_enable, cfg_wrap, cfg_proto_en, cfg_dip_en, cfg_clear;
  logic [7:0]   cfg_proto;
  logic [31:0]  cfg_dip;
  logic [255:0] ts_slots;
  logic [7:0]   slot_valid;
  logic [2:0]   wr_ptr;
  logic         full;
  logic [31:0]  match_count;
  logic [31:0]  pkt_count;

  int n_vec = 0;
  int n_err = 0;
  int pkt_n = 0;
  int n_sop = 0;
  logic         tog_en = 1'b0;
  logic [31:0]  tb_ts;
  logic [7:0]   prev_ctrl = 8'h00;
  logic [31:0]  sop_arr [0:255];
  logic [71:0]  exp_q [$];
  logic [71:0]  exp_w;

  pkt_ts_capture dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .cfg_enable(cfg_enable), .cfg_wrap(cfg_wrap), .cfg_proto_en(cfg_proto_en),
    .cfg_proto(cfg_proto), .cfg_dip_en(cfg_dip_en), .cfg_dip(cfg_dip), .cfg_clear(cfg_clear),
    .ts_slots(ts_slots), .slot_valid(slot_valid), .wr_ptr(wr_ptr), .full(full),
    .match_count(match_count), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  // Reference free-running timestamp
  always @(posedge clk) tb_ts <= reset ? 32'd0 : tb_ts + 32'd1;

  always @(posedge clk) begin
    #1;
    out_rdy = tog_en ? ~out_rdy : 1'b1;
  end

  // Output monitor: every forwarded word must be the next word sent, in order
  always @(negedge clk) begin
    if (!reset && out_wr) begin
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL fwd_extra observed=%h expected=none", {out_ctrl, out_data});
      end
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        n_vec++;
        assert ({out_ctrl, out_data} === exp_w) else begin
          n_err++;
          $error("FAIL fwd_word observed=%h expected=%h", {out_ctrl, out_data}, exp_w);
        end
      end
      if (out_ctrl == 8'h00 && prev_ctrl == 8'hff) begin
        sop_arr[n_sop] = tb_ts;
        n_sop++;
      end
      prev_ctrl = out_ctrl;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] slot(input int k);
    return ts_slots[k*32 +: 32];
  endfunction

  task automatic put_word(input logic [63:0] d, input logic [7:0] c);
    int t = 0;
    @(negedge clk);
    while (!in_rdy && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) chk("in_rdy_timeout", 64'(in_rdy), 64'd1);
    in_data = d;
    in_ctrl = c;
    in_wr   = 1'b1;
    exp_q.push_back({c, d});
    @(posedge clk);
    #1 in_wr = 1'b0;
  endtask

  task automatic send_pkt(input logic [15:0] et, input logic [7:0] proto,
                          input logic [31:0] dip, input int ndata);
    logic [63:0] d;
    logic [15:0] id;
    id = 16'(pkt_n);
    pkt_n++;
    put_word({32'h0, 16'h0001, id}, 8'hff);
    for (int i = 0; i < ndata; i++) begin
      case (i)
        0: d = {48'h0011_2233_4455, id};
        1: d = {32'h8899_aabb, et, 16'h4500};
        2: d = {16'h002e, id, 16'h4000, 8'h40, proto};
        3: d = {16'hbeef, 32'h0a00_0001, dip[31:16]};
        4: d = {dip[15:0], 16'h1111, id, 16'h5555};
        default: d = {id, 16'(i), 32'hcafe_f00d};
      endcase
      put_word(d, (i == ndata - 1) ? 8'h80 : 8'h00);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 64'(t < 2000), 64'd1);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(posedge clk);
    #1 cfg_clear = 1'b1;
    @(posedge clk);
    #1 cfg_clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_wr = 1'b0; in_data = '0; in_ctrl = '0;
    cfg_enable = 1'b1; cfg_wrap = 1'b0; cfg_proto_en = 1'b0; cfg_proto = 8'h00;
    cfg_dip_en = 1'b0; cfg_dip = 32'h0; cfg_clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_slot_valid", 64'(slot_valid), 64'd0);
    chk("rst_wr_ptr", 64'(wr_ptr), 64'd0);
    chk("rst_match", 64'(match_count), 64'd0);
    chk("rst_pkt", 64'(pkt_count), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_out_wr", 64'(out_wr), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    chk("rst_slots", 64'(|ts_slots), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // single UDP packet, filters off
    send_pkt(16'h0800, 8'h11, 32'hC0A8_0001, 7);
    drain();
    chk("t1_slot0", 64'(slot(0)), 64'(sop_arr[0]));
    chk("t1_valid", 64'(slot_valid), 64'h01);
    chk("t1_wr_ptr", 64'(wr_ptr), 64'd1);
    chk("t1_match", 64'(match_count), 64'd1);
    chk("t1_pkt", 64'(pkt_count), 64'd1);

    // protocol filter: TCP only
    pulse_clear();
    @(negedge clk);
    chk("clr_match", 64'(match_count), 64'd0);
    chk("clr_valid", 64'(slot_valid), 64'd0);
    cfg_proto_en = 1'b1; cfg_proto = 8'h06;
    send_pkt(16'h0800, 8'h11, 32'hC0A8_0001, 7);
    send_pkt(16'h0800, 8'h06, 32'hC0A8_0001, 7);
    send_pkt(16'h0800, 8'h11, 32'hC0A8_0001, 7);
    send_pkt(16'h0800, 8'h06, 32'hC0A8_0001, 7);
    send_pkt(16'h0800, 8'h11, 32'hC0A8_0001, 7);
    drain();
    chk("t2_match", 64'(match_count), 64'd2);
    chk("t2_pkt", 64'(pkt_count), 64'd5);
    chk("t2_valid", 64'(slot_valid), 64'h03);
    chk("t2_slot0", 64'(slot(0)), 64'(sop_arr[2]));
    chk("t2_slot1", 64'(slot(1)), 64'(sop_arr[4]));
    chk("t2_wr_ptr", 64'(wr_ptr), 64'd2);

    // destination IP filter
    pulse_clear();
    cfg_proto_en = 1'b0; cfg_dip_en = 1'b1; cfg_dip = 32'h0A00_0002;
    send_pkt(16'h0800, 8'h11, 32'h0A00_0002, 7);
    send_pkt(16'h0800, 8'h11, 32'h0A00_0003, 7);
    drain();
    chk("t3_match", 64'(match_count), 64'd1);
    chk("t3_pkt", 64'(pkt_count), 64'd2);
    chk("t3_valid", 64'(slot_valid), 64'h01);
    chk("t3_slot0", 64'(slot(0)), 64'(sop_arr[6]));

    // stop-when-full; EOP on the DIP-low word
    pulse_clear();
    cfg_dip_en = 1'b0; cfg_wrap = 1'b0;
    for (int i = 0; i < 10; i++) send_pkt(16'h0800, 8'h11, 32'h0A00_0009, 5);
    drain();
    chk("t4_full", 64'(full), 64'd1);
    chk("t4_match", 64'(match_count), 64'd8);
    chk("t4_pkt", 64'(pkt_count), 64'd10);
    chk("t4_valid", 64'(slot_valid), 64'hff);
    chk("t4_slot0", 64'(slot(0)), 64'(sop_arr[8]));
    chk("t4_slot7", 64'(slot(7)), 64'(sop_arr[15]));
    chk("t4_wr_ptr", 64'(wr_ptr), 64'd0);

    // wrap mode; EOP during the evaluation cycle
    pulse_clear();
    cfg_wrap = 1'b1;
    for (int i = 0; i < 10; i++) send_pkt(16'h0800, 8'h11, 32'h0A00_0009, 6);
    drain();
    chk("t4w_slot0", 64'(slot(0)), 64'(sop_arr[26]));
    chk("t4w_slot1", 64'(slot(1)), 64'(sop_arr[27]));
    chk("t4w_slot2", 64'(slot(2)), 64'(sop_arr[20]));
    chk("t4w_wr_ptr", 64'(wr_ptr), 64'd2);
    chk("t4w_match", 64'(match_count), 64'd10);
    chk("t4w_full", 64'(full), 64'd0);

    // ARP and a runt: forwarded, not counted
    send_pkt(16'h0806, 8'h11, 32'h0A00_0009, 7);
    send_pkt(16'h0800, 8'h11, 32'h0A00_0009, 2);
    drain();
    chk("t5_match", 64'(match_count), 64'd10);
    chk("t5_pkt", 64'(pkt_count), 64'd10);
    chk("t5_slot0", 64'(slot(0)), 64'(sop_arr[26]));

    // backpressure, then clear on a capturing EOP
    pulse_clear();
    tog_en = 1'b1;
    for (int i = 0; i < 3; i++) send_pkt(16'h0800, 8'h06, 32'h0A00_0004, 7);
    drain();
    chk("t6_match", 64'(match_count), 64'd3);
    chk("t6_slot2", 64'(slot(2)), 64'(sop_arr[32]));
    fork
      send_pkt(16'h0800, 8'h06, 32'h0A00_0004, 7);
      begin
        int t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!(out_wr && out_ctrl == 8'h80) && t < 2000);
        chk("t6_eop_seen", 64'(t < 2000), 64'd1);
        cfg_clear = 1'b1;
        @(posedge clk);
        #1 cfg_clear = 1'b0;
      end
    join
    drain();
    chk("t6_clr_match", 64'(match_count), 64'd0);
    chk("t6_clr_pkt", 64'(pkt_count), 64'd0);
    chk("t6_clr_valid", 64'(slot_valid), 64'd0);
    chk("t6_clr_wr_ptr", 64'(wr_ptr), 64'd0);
    send_pkt(16'h0800, 8'h06, 32'h0A00_0004, 7);
    send_pkt(16'h0800, 8'h06, 32'h0A00_0004, 7);
    drain();
    tog_en = 1'b0;
    chk("t6_slot0", 64'(slot(0)), 64'(sop_arr[34]));
    chk("t6_slot1", 64'(slot(1)), 64'(sop_arr[35]));
    chk("t6_wr_ptr", 64'(wr_ptr), 64'd2);
    chk("t6_match2", 64'(match_count), 64'd2);
    chk("t6_pkt2", 64'(pkt_count), 64'd2);
    chk("sop_total", 64'(n_sop), 64'd36);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
